store_commit_queue: RTL and testbench
=====================================

Name: store_commit_queue

Overview:
- Store queue between dispatch/LSU and data memory; the store counterpart to the reorder buffer's retire path.
- Allocates up to 2 stores/cycle at dispatch and captures address/data from LSU execution.
- Marks stores committed on the ROB's retire-store pulse, then drains committed stores in order to memory over a valid/ready write port.
- Flush discards only uncommitted (speculative) entries.

Parameters:
- NUM_SQ_ENTRY, 8: queue depth, power of 2.
- SQ_WIDTH, 3: log2(NUM_SQ_ENTRY).
- ROB_WIDTH, 4: ROB id width.
- ADDR_WIDTH, 32: address width (parameter_pkg).
- DATA_WIDTH, 32: data width, fixed at 32 for strobe generation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush.
- alloc_valid  in  2  bit0 = slot0 store, bit1 = slot1 store.
- alloc_rob_id_0 / alloc_rob_id_1  in  ROB_WIDTH  ROB id per slot.
- sq_id_0 / sq_id_1  out  SQ_WIDTH  assigned entry per slot (combinational from tail).
- sq_full  out  1  fewer than 2 free entries.
- sq_empty  out  1  count == 0.
- exec_valid  in  1  LSU store result valid.
- exec_sq_id  in  SQ_WIDTH  target entry.
- exec_addr  in  ADDR_WIDTH  byte address.
- exec_data  in  DATA_WIDTH  rs2 data.
- exec_funct3  in  3  SB=000, SH=001, SW=010.
- retire_store_valid  in  1  ROB store_valid: oldest uncommitted store retires.
- mem_wr_valid  out  1  write request.
- mem_wr_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_wr_data  out  DATA_WIDTH  lane-aligned data.
- mem_wr_strb  out  4  byte enables.
- mem_wr_ready  in  1  memory accepts.

Behaviour:
- Pointers and state:
  - head (drain), cmt (first uncommitted), tail (next alloc), count (SQ_WIDTH+1 bits); all wrap mod NUM_SQ_ENTRY.
  - Per entry: valid, executed, committed, rob_id, addr, data, strb.
  - Reset (rst=0, async): all pointers, count, entry flags = 0; mem_wr_valid=0, addr/data/strb=0, sq_empty=1, sq_full=0.
- Alloc:
  - 2'b11 writes tail and tail+1; 2'b01 or 2'b10 writes tail with the valid slot's rob_id.
  - sq_id_0 = tail; sq_id_1 = tail+1 if both valid, else tail; unused ids = 0.
  - Alloc while sq_full=1 is ignored (dispatch must stall).
- Execute: exec_valid sets executed and stores addr, data (replicated/shifted to byte lane), and strb.
  - SB: strb = 1<<addr[1:0].
  - SH: strb = 4'b0011<<{addr[1],1'b0}.
  - SW: strb = 4'hF.
  - Other funct3: strb = 0; entry drains as no-op.
- Retire: retire_store_valid sets committed[cmt] and cmt+1. Retiring an unexecuted entry is illegal (simulation assertion).
- Drain FSM:
  - IDLE: if entry[head] is committed, register addr/data/strb onto the mem_wr_* outputs and go to REQ.
  - REQ: mem_wr_valid=1 with outputs stable until mem_wr_ready. On accept, clear entry, head+1, count-1, go to IDLE.
  - A strb==0 entry is dropped in IDLE with no request.
  - Throughput is at most one store per 2 cycles.
- Flush:
  - tail <= cmt; count <= cmt - head (mod arithmetic, committed entries only); uncommitted entries invalidated.
  - An in-flight REQ completes; committed entries keep draining.
- Simultaneous events:
  - flush + alloc: alloc dropped.
  - flush + retire: retire applied first, so that entry survives.
  - alloc + drain accept: count = count + n_alloc - 1.
  - exec to an entry being flushed: ignored.
- Full queue: count == NUM_SQ_ENTRY is legal; sq_full asserts at count >= NUM_SQ_ENTRY-1.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: adds ports ld_addr (in, ADDR_WIDTH), fwd_hit (out, 1), fwd_data (out, DATA_WIDTH).
  - Combinational search, youngest to oldest from tail-1 to head, for a valid, executed entry with matching word address and strb==4'hF.
  - On the first match: fwd_hit=1 and fwd_data = that entry's data.
  - A partial-strobe match at the youngest matching word also forces fwd_hit=0, so the load waits for drain.
- Undefined: ports absent, no search logic.

Decomposition:
- typedef_pkg: SQ_ENTRY_t (valid, executed, committed, rob_id, addr, data, strb).
- instruction_pkg: FUNCT3_SB/SH/SW constants.
- Sub-module store_lane_align: funct3 + addr[1:0] + rs2 data -> strb and lane data; reused by the load path.

Test Plan:
- Reset then alloc 2'b11 ids 3,4 -> sq_id_0=0, sq_id_1=1, count=2, sq_empty=0.
- SW addr 0x100 data 0xDEADBEEF executed, retired, ready=1 after 2 cycles -> mem_wr_valid held 2 cycles, addr 0x100, strb 4'hF, head=1.
- SB addr 0x203 data 0x000000AB -> strb 4'b1000, mem_wr_data 0xAB000000, addr 0x200.
- Fill 8 entries, retire 3, flush -> count=3, tail=cmt=3, exactly 3 writes issued, then sq_empty=1.
- Wrap: 20 alloc/exec/retire/drain cycles on depth 8 -> writes in program order, no loss, pointers wrap correctly.
- STORE_FWD_EN: SW 0x40=0x11, then SW 0x40=0x22, ld_addr 0x40 -> fwd_hit=1, fwd_data=0x22; add SB 0x41 after both -> fwd_hit=0.

Source files
------------

// File: rtl/store_commit_queue_pkg.sv
// Shared types and constants for the store commit queue.
//   SQ_ENTRY_t     : per-entry state (flags, ROB id, address, lane data, strobe)
//   FUNCT3_*       : RISC-V store width encodings
//   drain_state_t  : memory write-port drain FSM states
package store_commit_queue_pkg;

  localparam int unsigned SQ_ROB_W  = 4;
  localparam int unsigned SQ_ADDR_W = 32;
  localparam int unsigned SQ_DATA_W = 32;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef struct packed {
    logic                 valid;
    logic                 executed;
    logic                 committed;
    logic [SQ_ROB_W-1:0]  rob_id;
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [3:0]           strb;
  } SQ_ENTRY_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_REQ
  } drain_state_t;

endpackage

// File: rtl/store_commit_queue_align.sv
// store_lane_align: converts a store's funct3, low address bits and rs2 data
// into byte strobes and lane-aligned write data. Shared with the load path.
//   funct3    in  store width (SB/SH/SW; anything else gives strb=0)
//   addr_lo   in  address bits [1:0]
//   rs2_data  in  raw register data
//   strb      out byte enables
//   lane_data out data shifted into its byte lanes
module store_lane_align
  import store_commit_queue_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  output logic [3:0]  strb,
  output logic [31:0] lane_data
);

  always_comb begin
    strb      = '0;
    lane_data = '0;
    case (funct3)
      FUNCT3_SB: begin
        strb      = 4'b0001 << addr_lo;
        lane_data = {24'b0, rs2_data[7:0]} << {addr_lo, 3'b000};
      end
      FUNCT3_SH: begin
        strb      = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data = {16'b0, rs2_data[15:0]} << {addr_lo[1], 4'b0000};
      end
      FUNCT3_SW: begin
        strb      = 4'hF;
        lane_data = rs2_data;
      end
      default: begin
        strb      = '0;
        lane_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/store_commit_queue.sv
// store_commit_queue: in-order store queue between dispatch/LSU and memory.
// Allocates up to two stores per cycle, captures address/data at execute,
// marks stores committed on ROB retire, and drains committed stores to
// memory over a valid/ready write port. Flush drops speculative entries only.
// Ports:
//   clk, rst (async, active-low), flush
//   alloc_valid[1:0], alloc_rob_id_0/1 -> sq_id_0/1, sq_full, sq_empty
//   exec_valid, exec_sq_id, exec_addr, exec_data, exec_funct3
//   retire_store_valid
//   mem_wr_valid/addr/data/strb, mem_wr_ready
// Optional macro STORE_FWD_EN adds ld_addr -> fwd_hit/fwd_data forwarding.
module store_commit_queue
  import store_commit_queue_pkg::*;
#(
  parameter int unsigned NUM_SQ_ENTRY = 8,
  parameter int unsigned SQ_WIDTH     = 3,
  parameter int unsigned ROB_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            alloc_valid,
  input  logic [ROB_WIDTH-1:0]  alloc_rob_id_0,
  input  logic [ROB_WIDTH-1:0]  alloc_rob_id_1,
  output logic [SQ_WIDTH-1:0]   sq_id_0,
  output logic [SQ_WIDTH-1:0]   sq_id_1,
  output logic                  sq_full,
  output logic                  sq_empty,
  input  logic                  exec_valid,
  input  logic [SQ_WIDTH-1:0]   exec_sq_id,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_data,
  input  logic [2:0]            exec_funct3,
  input  logic                  retire_store_valid,
  output logic                  mem_wr_valid,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_wr_strb,
`ifdef STORE_FWD_EN
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  input  logic                  mem_wr_ready
);

  SQ_ENTRY_t           sq [NUM_SQ_ENTRY];
  logic [SQ_WIDTH-1:0] head, cmt, tail;
  logic [SQ_WIDTH:0]   count;
  drain_state_t        state;

  logic [3:0]            exec_strb;
  logic [DATA_WIDTH-1:0] exec_lane_data;

  logic                    alloc_en;
  logic [1:0]              n_alloc;
  logic                    drain_fire;
  logic [SQ_WIDTH-1:0]     cmt_n, head_n, keep_diff;
  logic [SQ_WIDTH:0]       flush_count;
  logic [NUM_SQ_ENTRY-1:0] committed_n;

  store_lane_align u_align (
    .funct3    (exec_funct3),
    .addr_lo   (exec_addr[1:0]),
    .rs2_data  (exec_data),
    .strb      (exec_strb),
    .lane_data (exec_lane_data)
  );

  assign sq_full  = count >= (SQ_WIDTH+1)'(NUM_SQ_ENTRY - 1);
  assign sq_empty = count == '0;

  always_comb begin
    sq_id_0 = '0;
    sq_id_1 = '0;
    case (alloc_valid)
      2'b01: sq_id_0 = tail;
      2'b10: sq_id_1 = tail;
      2'b11: begin
        sq_id_0 = tail;
        sq_id_1 = tail + SQ_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    alloc_en   = !flush && !sq_full;
    n_alloc    = alloc_en ? ({1'b0, alloc_valid[0]} + {1'b0, alloc_valid[1]}) : 2'd0;
    drain_fire = (state == DRAIN_IDLE && sq[head].valid && sq[head].committed &&
                  sq[head].strb == '0) ||
                 (state == DRAIN_REQ && mem_wr_ready);
    cmt_n  = cmt + SQ_WIDTH'(retire_store_valid);
    head_n = head + SQ_WIDTH'(drain_fire);
    // Committed status after this cycle's retire; these entries survive a flush.
    for (int unsigned i = 0; i < NUM_SQ_ENTRY; i++)
      committed_n[i] = sq[i].valid &&
                       (sq[i].committed || (retire_store_valid && cmt == SQ_WIDTH'(i)));
    // cmt == head is ambiguous between "none kept" and "all kept"; the head
    // entry's committed flag breaks the tie.
    keep_diff   = cmt_n - head_n;
    flush_count = (keep_diff == '0 && committed_n[head_n]) ?
                  (SQ_WIDTH+1)'(NUM_SQ_ENTRY) : {1'b0, keep_diff};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SQ_ENTRY; i++) sq[i] <= '0;
      head         <= '0;
      cmt          <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= DRAIN_IDLE;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_strb  <= '0;
    end else begin
      if (exec_valid && sq[exec_sq_id].valid && (!flush || committed_n[exec_sq_id])) begin
        sq[exec_sq_id].executed <= 1'b1;
        sq[exec_sq_id].addr     <= exec_addr;
        sq[exec_sq_id].data     <= exec_lane_data;
        sq[exec_sq_id].strb     <= exec_strb;
      end

      if (retire_store_valid) sq[cmt].committed <= 1'b1;
      cmt <= cmt_n;

      if (alloc_en) begin
        case (alloc_valid)
          2'b01: sq[tail] <= '{valid: 1'b1, executed: 1'b0, committed: 1'b0,
                               rob_id: alloc_rob_id_0, addr: '0, data: '0, strb: '0};
          2'b10: sq[tail] <= '{valid: 1'b1, executed: 1'b0, committed: 1'b0,
                               rob_id: alloc_rob_id_1, addr: '0, data: '0, strb: '0};
          2'b11: begin
            sq[tail] <= '{valid: 1'b1, executed: 1'b0, committed: 1'b0,
                          rob_id: alloc_rob_id_0, addr: '0, data: '0, strb: '0};
            sq[tail + SQ_WIDTH'(1)] <= '{valid: 1'b1, executed: 1'b0, committed: 1'b0,
                                         rob_id: alloc_rob_id_1, addr: '0, data: '0, strb: '0};
          end
          default: ;
        endcase
      end

      case (state)
        DRAIN_IDLE: begin
          if (sq[head].valid && sq[head].committed) begin
            if (sq[head].strb == '0) begin
              sq[head] <= '0;
            end else begin
              mem_wr_valid <= 1'b1;
              mem_wr_addr  <= {sq[head].addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wr_data  <= sq[head].data;
              mem_wr_strb  <= sq[head].strb;
              state        <= DRAIN_REQ;
            end
          end
        end
        DRAIN_REQ: begin
          if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
            sq[head]     <= '0;
            state        <= DRAIN_IDLE;
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
      head <= head_n;

      if (flush) begin
        tail  <= cmt_n;
        count <= flush_count;
        for (int unsigned i = 0; i < NUM_SQ_ENTRY; i++) begin
          if (!committed_n[i]) begin
            sq[i].valid    <= 1'b0;
            sq[i].executed <= 1'b0;
          end
        end
      end else begin
        tail  <= tail + SQ_WIDTH'(n_alloc);
        count <= count + (SQ_WIDTH+1)'(n_alloc) - (SQ_WIDTH+1)'(drain_fire);
      end
    end
  end

  // Retiring a store whose address/data have not been captured is illegal.
  assert property (@(posedge clk) disable iff (!rst)
    retire_store_valid |-> (sq[cmt].valid && sq[cmt].executed));

`ifdef STORE_FWD_EN
  logic [SQ_WIDTH-1:0] fwd_idx;
  logic                fwd_found;

  // Youngest-first search; the first word match decides, so a younger
  // partial-strobe store blocks forwarding from an older full-word store.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    fwd_found = 1'b0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < NUM_SQ_ENTRY; i++) begin
      fwd_idx = tail - SQ_WIDTH'(i + 1);
      if (!fwd_found && sq[fwd_idx].valid && sq[fwd_idx].executed &&
          ((sq[fwd_idx].addr ^ ld_addr) >> 2) == '0) begin
        fwd_found = 1'b1;
        if (sq[fwd_idx].strb == 4'hF) begin
          fwd_hit  = 1'b1;
          fwd_data = sq[fwd_idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
module tb_store_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  alloc_valid;
  logic [3:0]  alloc_rob_id_0, alloc_rob_id_1;
  logic [2:0]  sq_id_0, sq_id_1;
  logic        sq_full, sq_empty;
  logic        exec_valid;
  logic [2:0]  exec_sq_id;
  logic [31:0] exec_addr, exec_data;
  logic [2:0]  exec_funct3;
  logic        retire_store_valid;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ready;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  store_commit_queue #(
    .NUM_SQ_ENTRY (8),
    .SQ_WIDTH     (3),
    .ROB_WIDTH    (4),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .alloc_valid        (alloc_valid),
    .alloc_rob_id_0     (alloc_rob_id_0),
    .alloc_rob_id_1     (alloc_rob_id_1),
    .sq_id_0            (sq_id_0),
    .sq_id_1            (sq_id_1),
    .sq_full            (sq_full),
    .sq_empty           (sq_empty),
    .exec_valid         (exec_valid),
    .exec_sq_id         (exec_sq_id),
    .exec_addr          (exec_addr),
    .exec_data          (exec_data),
    .exec_funct3        (exec_funct3),
    .retire_store_valid (retire_store_valid),
    .mem_wr_valid       (mem_wr_valid),
    .mem_wr_addr        (mem_wr_addr),
    .mem_wr_data        (mem_wr_data),
    .mem_wr_strb        (mem_wr_strb),
`ifdef STORE_FWD_EN
    .ld_addr            (ld_addr),
    .fwd_hit            (fwd_hit),
    .fwd_data           (fwd_data),
`endif
    .mem_wr_ready       (mem_wr_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_exec(input logic [2:0] id, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
    exec_valid  = 1'b1;
    exec_sq_id  = id;
    exec_addr   = a;
    exec_data   = d;
    exec_funct3 = f3;
    tick();
    exec_valid  = 1'b0;
  endtask

  task automatic do_retire();
    retire_store_valid = 1'b1;
    tick();
    retire_store_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e_id;
    int         writes;

    rst = 1'b0; flush = 1'b0; alloc_valid = 2'b00;
    alloc_rob_id_0 = '0; alloc_rob_id_1 = '0;
    exec_valid = 1'b0; exec_sq_id = '0; exec_addr = '0; exec_data = '0; exec_funct3 = '0;
    retire_store_valid = 1'b0; mem_wr_ready = 1'b0;
`ifdef STORE_FWD_EN
    ld_addr = '0;
`endif

    // Reset state
    #12;
    check("rst_empty", 32'(sq_empty), 32'd1);
    check("rst_full", 32'(sq_full), 32'd0);
    check("rst_wr_valid", 32'(mem_wr_valid), 32'd0);
    check("rst_wr_addr", mem_wr_addr, 32'd0);
    check("rst_wr_strb", 32'(mem_wr_strb), 32'd0);
    rst = 1'b1;

    // Dual alloc, ROB ids 3 and 4
    alloc_valid = 2'b11; alloc_rob_id_0 = 4'd3; alloc_rob_id_1 = 4'd4;
    #1;
    check("alloc11_id0", 32'(sq_id_0), 32'd0);
    check("alloc11_id1", 32'(sq_id_1), 32'd1);
    tick();
    alloc_valid = 2'b00;
    check("alloc11_count", 32'(dut.count), 32'd2);
    check("alloc11_empty", 32'(sq_empty), 32'd0);

    // SW 0x100 = DEADBEEF, ready held off for two request cycles
    do_exec(3'd0, 32'h100, 32'hDEADBEEF, 3'b010);
    do_retire();
    check("sw_no_req_yet", 32'(mem_wr_valid), 32'd0);
    tick();
    check("sw_valid_c1", 32'(mem_wr_valid), 32'd1);
    check("sw_addr", mem_wr_addr, 32'h100);
    check("sw_data", mem_wr_data, 32'hDEADBEEF);
    check("sw_strb", 32'(mem_wr_strb), 32'hF);
    tick();
    check("sw_valid_c2", 32'(mem_wr_valid), 32'd1);
    check("sw_addr_stable", mem_wr_addr, 32'h100);
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    check("sw_done_valid", 32'(mem_wr_valid), 32'd0);
    check("sw_head", 32'(dut.head), 32'd1);
    check("sw_count", 32'(dut.count), 32'd1);

    // SB 0x203 = 0xAB
    do_exec(3'd1, 32'h203, 32'h000000AB, 3'b000);
    do_retire();
    tick();
    check("sb_valid", 32'(mem_wr_valid), 32'd1);
    check("sb_addr", mem_wr_addr, 32'h200);
    check("sb_data", mem_wr_data, 32'hAB000000);
    check("sb_strb", 32'(mem_wr_strb), 32'h8);
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    check("sb_done_valid", 32'(mem_wr_valid), 32'd0);
    check("sb_empty", 32'(sq_empty), 32'd1);

    // Slot-1-only alloc, SH 0x302 = 0x1234
    alloc_valid = 2'b10; alloc_rob_id_1 = 4'd5;
    #1;
    check("alloc10_id0", 32'(sq_id_0), 32'd0);
    check("alloc10_id1", 32'(sq_id_1), 32'd2);
    tick();
    alloc_valid = 2'b00;
    do_exec(3'd2, 32'h302, 32'h00001234, 3'b001);
    do_retire();
    tick();
    check("sh_addr", mem_wr_addr, 32'h300);
    check("sh_data", mem_wr_data, 32'h12340000);
    check("sh_strb", 32'(mem_wr_strb), 32'hC);
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;

    // Unsupported funct3: drained silently
    alloc_valid = 2'b01; alloc_rob_id_0 = 4'd6;
    #1;
    check("alloc01_id0", 32'(sq_id_0), 32'd3);
    check("alloc01_id1", 32'(sq_id_1), 32'd0);
    tick();
    alloc_valid = 2'b00;
    do_exec(3'd3, 32'h500, 32'h55, 3'b111);
    do_retire();
    tick();
    check("noop_no_req", 32'(mem_wr_valid), 32'd0);
    check("noop_empty", 32'(sq_empty), 32'd1);
    check("noop_head", 32'(dut.head), 32'd4);

    // Fill all 8 entries (indices 4..7,0..3)
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 2'b11; alloc_rob_id_0 = 4'(2*k); alloc_rob_id_1 = 4'(2*k+1);
      tick();
    end
    check("fill_full", 32'(sq_full), 32'd1);
    check("fill_count", 32'(dut.count), 32'd8);
    tick();  // alloc while full is ignored
    alloc_valid = 2'b00;
    check("full_alloc_ignored", 32'(dut.count), 32'd8);
    for (int k = 0; k < 8; k++)
      do_exec(3'(4 + k), 32'h1000 + 32'(4*k), 32'hA0 + 32'(k), 3'b010);
    for (int k = 0; k < 3; k++) do_retire();
    flush = 1'b1; alloc_valid = 2'b11;  // alloc concurrent with flush is dropped
    tick();
    flush = 1'b0; alloc_valid = 2'b00;
    check("flush_count", 32'(dut.count), 32'd3);
    check("flush_tail", 32'(dut.tail), 32'd7);
    check("flush_cmt", 32'(dut.cmt), 32'd7);
    check("flush_not_full", 32'(sq_full), 32'd0);
    mem_wr_ready = 1'b1;
    writes = 0;
    for (int t = 0; t < 12; t++) begin
      if (mem_wr_valid) begin
        check("flush_drain_addr", mem_wr_addr, 32'h1000 + 32'(4*writes));
        check("flush_drain_data", mem_wr_data, 32'hA0 + 32'(writes));
        writes++;
      end
      tick();
    end
    check("flush_write_count", 32'(writes), 32'd3);
    check("flush_drained_empty", 32'(sq_empty), 32'd1);

    // 20 stores through the depth-8 queue with pointer wrap
    for (int k = 0; k < 20; k++) begin
      e_id = 3'(7 + k);
      alloc_valid = 2'b01; alloc_rob_id_0 = 4'(k);
      #1;
      check("wrap_sq_id", 32'(sq_id_0), 32'(e_id));
      tick();
      alloc_valid = 2'b00;
      do_exec(e_id, 32'h2000 + 32'(4*k), 32'hC000 + 32'(k), 3'b010);
      do_retire();
      for (int t = 0; t < 10 && !mem_wr_valid; t++) tick();
      check("wrap_req_seen", 32'(mem_wr_valid), 32'd1);
      check("wrap_addr", mem_wr_addr, 32'h2000 + 32'(4*k));
      check("wrap_data", mem_wr_data, 32'hC000 + 32'(k));
      tick();
    end
    mem_wr_ready = 1'b0;
    check("wrap_head", 32'(dut.head), 32'd3);
    check("wrap_tail", 32'(dut.tail), 32'd3);
    check("wrap_empty", 32'(sq_empty), 32'd1);

`ifdef STORE_FWD_EN
    alloc_valid = 2'b11; alloc_rob_id_0 = 4'd1; alloc_rob_id_1 = 4'd2;
    tick();
    alloc_valid = 2'b00;
    do_exec(3'd3, 32'h40, 32'h11, 3'b010);
    do_exec(3'd4, 32'h40, 32'h22, 3'b010);
    ld_addr = 32'h40;
    #1;
    check("fwd_hit_young", 32'(fwd_hit), 32'd1);
    check("fwd_data_young", fwd_data, 32'h22);
    ld_addr = 32'h44;
    #1;
    check("fwd_miss_other_word", 32'(fwd_hit), 32'd0);
    alloc_valid = 2'b01; alloc_rob_id_0 = 4'd3;
    tick();
    alloc_valid = 2'b00;
    do_exec(3'd5, 32'h41, 32'h77, 3'b000);
    ld_addr = 32'h40;
    #1;
    check("fwd_partial_block", 32'(fwd_hit), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fwd_flush_empty", 32'(sq_empty), 32'd1);
    check("fwd_flush_nohit", 32'(fwd_hit), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
